// File: rtl/down_timer.sv
// Programmable down-counting timer.
// Loads a period on start, counts down on enabled cycles and strobes tick
// for one cycle on expiry. Supports one-shot and auto-reload operation.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | not counting; cnt holds its last value
// RUN   | counting down on enabled cycles; busy is high
module down_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  input  logic             enable,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_reg, period_nxt;
  logic             mode_reg, mode_nxt;
  logic             tick_nxt, err_nxt;

  // State and datapath registers; reset overrides every command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tick       <= 1'b0;
      err        <= 1'b0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tick       <= tick_nxt;
      err        <= err_nxt;
      period_reg <= period_nxt;
      mode_reg   <= mode_nxt;
    end
  end

  // Next-state logic: stop beats start, start beats counting. An illegal
  // (zero-period) start still counts as a command, so the count holds that cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    tick_nxt   = 1'b0;
    err_nxt    = 1'b0;
    period_nxt = period_reg;
    mode_nxt   = mode_reg;

    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (start) begin
      if (period != '0) begin
        period_nxt = period;
        mode_nxt   = periodic;
        cnt_nxt    = period;
        state_nxt  = RUN;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (state == RUN && enable) begin
      if (cnt > ONE) begin
        cnt_nxt = cnt - ONE;
      end else if (cnt == ONE) begin
        tick_nxt = 1'b1;
        if (mode_reg) begin
          cnt_nxt = period_reg;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
    end
  end

  // busy follows the registered state directly.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: the stimulus process pushes the
// hand-computed expected outputs for each cycle, a monitor pops and compares.
module tb_down_timer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset, start, stop, periodic, enable;
  logic [W-1:0] period;
  logic [W-1:0] cnt;
  logic         tick, busy, err;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tick;
    logic         busy;
    logic         err;
    string        name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .enable(enable),
    .cnt(cnt), .tick(tick), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".cnt"},  int'(cnt),  int'(e.cnt));
        check({e.name, ".tick"}, int'(tick), int'(e.tick));
        check({e.name, ".busy"}, int'(busy), int'(e.busy));
        check({e.name, ".err"},  int'(err),  int'(e.err));
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic s, input logic sp,
                      input logic pm, input logic [W-1:0] p, input logic en,
                      input logic [W-1:0] ec, input logic et, input logic eb,
                      input logic ee, input string nm);
    exp_t e;
    e.cnt = ec; e.tick = et; e.busy = eb; e.err = ee; e.name = nm;
    q.push_back(e);
    reset = r; start = s; stop = sp; periodic = pm; period = p; enable = en;
    @(posedge clk);
    #3;
  endtask

  initial begin
    // Reset dominates a simultaneous start.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 4, 1, 0, 0, 0, 0, "rst");

    // One-shot, period 4.
    step(0, 1, 0, 0, 4, 1, 4, 0, 1, 0, "os_load");
    step(0, 0, 0, 0, 0, 1, 3, 0, 1, 0, "os_3");
    step(0, 0, 0, 0, 0, 1, 2, 0, 1, 0, "os_2");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "os_1");
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, "os_tick");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "os_idle");

    // Periodic, period 3, 12 enabled cycles.
    step(0, 1, 0, 1, 3, 1, 3, 0, 1, 0, "p3_load");
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 0, 0, 1, (i % 3 == 1) ? 12'd2 : (i % 3 == 2) ? 12'd1 : 12'd3,
           (i % 3 == 0), 1, 0, "p3_run");
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, "p3_stop");

    // Periodic, period 5, enable dropped for 3 cycles at cnt=2.
    step(0, 1, 0, 1, 5, 1, 5, 0, 1, 0, "p5_load");
    step(0, 0, 0, 0, 0, 1, 4, 0, 1, 0, "p5_4");
    step(0, 0, 0, 0, 0, 1, 3, 0, 1, 0, "p5_3");
    step(0, 0, 0, 0, 0, 1, 2, 0, 1, 0, "p5_2");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 2, 0, 1, 0, "p5_hold");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "p5_1");
    step(0, 0, 0, 0, 0, 1, 5, 1, 1, 0, "p5_tick");
    step(0, 0, 0, 0, 0, 1, 4, 0, 1, 0, "p5_r4");
    step(0, 0, 0, 0, 0, 1, 3, 0, 1, 0, "p5_r3");
    step(0, 0, 0, 0, 0, 1, 2, 0, 1, 0, "p5_r2");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "p5_r1");
    step(0, 0, 0, 0, 0, 1, 5, 1, 1, 0, "p5_tick2");
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, "p5_stop");

    // Retrigger on the expiry edge discards the tick; stop beats start.
    step(0, 1, 0, 1, 3, 1, 3, 0, 1, 0, "rt_load");
    step(0, 0, 0, 0, 0, 1, 2, 0, 1, 0, "rt_2");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "rt_1");
    step(0, 1, 0, 1, 7, 1, 7, 0, 1, 0, "rt_reload7");
    step(0, 0, 0, 0, 0, 1, 6, 0, 1, 0, "rt_6");
    step(0, 1, 1, 1, 9, 1, 0, 0, 0, 0, "rt_stop_start");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rt_idle");

    // Illegal start in IDLE, then during RUN with period_reg=6.
    step(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, "err_idle");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "err_idle_clr");
    step(0, 1, 0, 1, 6, 1, 6, 0, 1, 0, "er_load");
    step(0, 0, 0, 0, 0, 1, 5, 0, 1, 0, "er_5");
    step(0, 0, 0, 0, 0, 1, 4, 0, 1, 0, "er_4");
    step(0, 1, 0, 0, 0, 1, 4, 0, 1, 1, "err_run");
    step(0, 0, 0, 0, 0, 1, 3, 0, 1, 0, "er_3");
    step(0, 0, 0, 0, 0, 1, 2, 0, 1, 0, "er_2");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "er_1");
    step(0, 0, 0, 0, 0, 1, 6, 1, 1, 0, "er_tick");

    // Reset on the expiry edge suppresses the tick.
    step(0, 1, 0, 1, 2, 1, 2, 0, 1, 0, "rs_load");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "rs_1");
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rs_reset");

    // Period 1 periodic: tick every enabled cycle.
    step(0, 1, 0, 1, 1, 1, 1, 0, 1, 0, "p1_load");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, "p1_tick");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "p1_frozen");
    step(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, "p1_tick_again");
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, "p1_stop");

    // Maximum period.
    step(0, 1, 0, 0, 12'hFFF, 1, 12'hFFF, 0, 1, 0, "max_load");
    step(0, 0, 0, 0, 0, 1, 12'hFFE, 0, 1, 0, "max_dec");
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, "max_stop");

    reset = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
